// File: rtl/traffic_light_fsm_if.sv
// Interval request bus between the sequencer and the time-parameter block.
// The sequencer drives the select code and receives the interval length.
interface traffic_light_fsm_if;
  logic [1:0] interval_sel;
  logic [3:0] time_value;

  modport master (
    output interval_sel,
    input  time_value
  );

  modport slave (
    input  interval_sel,
    output time_value
  );
endinterface

// File: rtl/traffic_light_fsm.sv
// Intersection sequencer: lamp state machine, interval load and countdown,
// side-street sensor, latched pedestrian request and reprogram restart.
module traffic_light_fsm #(
  parameter logic [1:0] BASE_SEL     = 2'b00,
  parameter logic [1:0] EXT_SEL      = 2'b01,
  parameter logic [1:0] YEL_SEL      = 2'b10,
  parameter int         LOAD_LATENCY = 2
) (
  input  logic       clk,
  input  logic       global_reset_n,
  input  logic       sec_tick,
  input  logic       sensor,
  input  logic       walk_request,
  input  logic       reprogram,
  traffic_light_fsm_if.master tp,
  output logic [2:0] main_lights,
  output logic [2:0] side_lights,
  output logic       walk_lamp,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] MG_BASE = 3'd0;
  localparam logic [2:0] MG_EXT  = 3'd1;
  localparam logic [2:0] MY      = 3'd2;
  localparam logic [2:0] SG_BASE = 3'd3;
  localparam logic [2:0] SG_EXT  = 3'd4;
  localparam logic [2:0] SY      = 3'd5;
  localparam logic [2:0] WALK    = 3'd6;

  localparam int LW = (LOAD_LATENCY < 2) ? 1
                                         : $clog2(LOAD_LATENCY);
  localparam logic [LW-1:0] LOAD_LAST = LW'(LOAD_LATENCY - 1);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  logic [2:0]    state;
  logic [2:0]    nxt;
  logic [3:0]    timer;
  logic          armed;
  logic [LW-1:0] load_cnt;
  logic          walk_pending;
  logic          expire;
  logic          load;

  assign expire = armed && sec_tick && (timer == 4'd1);
  assign load   = !armed && (load_cnt == LOAD_LAST);

  always_comb begin
    nxt = state;
    case (state)
      MG_BASE: nxt = sensor ? MG_EXT : MY;
      MG_EXT:  nxt = MY;
      MY:      nxt = SG_BASE;
      SG_BASE: nxt = sensor ? SG_EXT : SY;
      SG_EXT:  nxt = SY;
      SY:      nxt = walk_pending ? WALK : MG_BASE;
      WALK:    nxt = MG_BASE;
      default: nxt = MG_BASE;
    endcase
  end

  // Every interval restarts with a load phase; the loaded value is never
  // decremented on its own load edge because load only happens unarmed.
  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state    <= MG_BASE;
      timer    <= 4'd0;
      armed    <= 1'b0;
      load_cnt <= '0;
    end else if (reprogram) begin
      state    <= MG_BASE;
      armed    <= 1'b0;
      load_cnt <= '0;
    end else if (expire) begin
      state    <= nxt;
      timer    <= 4'd0;
      armed    <= 1'b0;
      load_cnt <= '0;
    end else if (armed) begin
      if (sec_tick && timer != 4'd0)
        timer <= timer - 4'd1;
    end else if (load) begin
      timer <= (tp.time_value == 4'd0) ? 4'd1
                                       : tp.time_value;
      armed <= 1'b1;
    end else begin
      load_cnt <= load_cnt + LW'(1);
    end
  end

  // A request on the WALK entry edge is consumed by that walk.
  always_ff @(posedge clk or negedge global_reset_n) begin
    if (!global_reset_n)
      walk_pending <= 1'b0;
    else if (!reprogram && expire && nxt == WALK)
      walk_pending <= 1'b0;
    else if (walk_request)
      walk_pending <= 1'b1;
  end

  always_comb begin
    main_lights     = RED;
    side_lights     = RED;
    walk_lamp       = 1'b0;
    tp.interval_sel = BASE_SEL;
    case (state)
      MG_BASE: begin
        main_lights     = GRN;
        tp.interval_sel = BASE_SEL;
      end
      MG_EXT: begin
        main_lights     = GRN;
        tp.interval_sel = EXT_SEL;
      end
      MY: begin
        main_lights     = YEL;
        tp.interval_sel = YEL_SEL;
      end
      SG_BASE: begin
        side_lights     = GRN;
        tp.interval_sel = BASE_SEL;
      end
      SG_EXT: begin
        side_lights     = GRN;
        tp.interval_sel = EXT_SEL;
      end
      SY: begin
        side_lights     = YEL;
        tp.interval_sel = YEL_SEL;
      end
      WALK: begin
        walk_lamp       = 1'b1;
        tp.interval_sel = EXT_SEL;
      end
      default: begin
        main_lights     = RED;
        tp.interval_sel = BASE_SEL;
      end
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed vector bench for the intersection sequencer, with a registered
// time-parameter model answering 6/3/2 for base/extended/yellow.
module tb_traffic_light_fsm;

  localparam logic [2:0] S_MGB  = 3'd0;
  localparam logic [2:0] S_MGE  = 3'd1;
  localparam logic [2:0] S_MY   = 3'd2;
  localparam logic [2:0] S_SGB  = 3'd3;
  localparam logic [2:0] S_SGE  = 3'd4;
  localparam logic [2:0] S_SY   = 3'd5;
  localparam logic [2:0] S_WALK = 3'd6;

  typedef struct {
    logic       rst_n;
    logic       reprog;
    logic       sensor;
    logic       walk;
    logic       tick;
    int         n;
    logic [2:0] st;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sec_tick = 1'b0;
  logic       sensor = 1'b0;
  logic       walk_request = 1'b0;
  logic       reprogram = 1'b0;
  logic       tv_zero = 1'b0;
  logic [2:0] main_lights;
  logic [2:0] side_lights;
  logic       walk_lamp;
  logic [2:0] state_dbg;

  int    n_vec = 0;
  int    n_bad = 0;
  string tag;
  vec_t  tbl[$];

  traffic_light_fsm_if tp ();

  traffic_light_fsm dut (
    .clk            (clk),
    .global_reset_n (rst_n),
    .sec_tick       (sec_tick),
    .sensor         (sensor),
    .walk_request   (walk_request),
    .reprogram      (reprogram),
    .tp             (tp.master),
    .main_lights    (main_lights),
    .side_lights    (side_lights),
    .walk_lamp      (walk_lamp),
    .state_dbg      (state_dbg)
  );

  always #5 clk = ~clk;

  initial tp.time_value = 4'd6;
  always @(posedge clk) begin
    if (tv_zero)
      tp.time_value <= 4'd0;
    else
      case (tp.interval_sel)
        2'b00:   tp.time_value <= 4'd6;
        2'b01:   tp.time_value <= 4'd3;
        2'b10:   tp.time_value <= 4'd2;
        default: tp.time_value <= 4'd15;
      endcase
  end

  task automatic check(input logic [2:0] st);
    logic [2:0] em;
    logic [2:0] es;
    logic       ew;
    logic [1:0] el;
    em = 3'b100; es = 3'b100; ew = 1'b0; el = 2'b00;
    case (st)
      S_MGB:  begin em = 3'b001; el = 2'b00; end
      S_MGE:  begin em = 3'b001; el = 2'b01; end
      S_MY:   begin em = 3'b010; el = 2'b10; end
      S_SGB:  begin es = 3'b001; el = 2'b00; end
      S_SGE:  begin es = 3'b001; el = 2'b01; end
      S_SY:   begin es = 3'b010; el = 2'b10; end
      S_WALK: begin ew = 1'b1;   el = 2'b01; end
      default: ;
    endcase
    n_vec++;
    if (state_dbg !== st || main_lights !== em ||
        side_lights !== es || walk_lamp !== ew ||
        tp.interval_sel !== el) begin
      n_bad++;
      $display("FAIL %s t=%0t: st/main/side/walk/sel got %0d/%b/%b/%b/%b want %0d/%b/%b/%b/%b",
               tag, $time, state_dbg, main_lights, side_lights,
               walk_lamp, tp.interval_sel, st, em, es, ew, el);
    end
  endtask

  task automatic apply(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      rst_n        = v.rst_n;
      reprogram    = v.reprog;
      sensor       = v.sensor;
      walk_request = v.walk;
      sec_tick     = v.tick;
      @(posedge clk);
      #1;
      check(v.st);
    end
  endtask

  task automatic add(input logic r, input logic p, input logic s,
                     input logic w, input logic t, input int n,
                     input logic [2:0] st);
    vec_t v;
    v.rst_n = r; v.reprog = p; v.sensor = s;
    v.walk = w; v.tick = t; v.n = n; v.st = st;
    tbl.push_back(v);
  endtask

  task automatic run(input string nm, input logic r, input logic p,
                     input logic s, input logic w, input logic t,
                     input int n, input logic [2:0] st);
    vec_t v;
    tag = nm;
    v.rst_n = r; v.reprog = p; v.sensor = s;
    v.walk = w; v.tick = t; v.n = n; v.st = st;
    apply(v);
  endtask

  initial begin
    // reset, then sensor=0 round
    add(0, 0, 0, 0, 0, 2, S_MGB);
    add(1, 0, 0, 0, 1, 7, S_MGB);
    add(1, 0, 0, 0, 1, 4, S_MY);
    add(1, 0, 0, 0, 1, 8, S_SGB);
    add(1, 0, 0, 0, 1, 4, S_SY);
    add(1, 0, 0, 0, 1, 8, S_MGB);
    // sensor=1 round
    add(1, 0, 1, 0, 1, 5, S_MGE);
    add(1, 0, 1, 0, 1, 4, S_MY);
    add(1, 0, 1, 0, 1, 8, S_SGB);
    add(1, 0, 1, 0, 1, 5, S_SGE);
    add(1, 0, 1, 0, 1, 4, S_SY);
    add(1, 0, 0, 0, 1, 8, S_MGB);
    // walk pulse in SG_BASE, second pulse during WALK
    add(1, 0, 0, 0, 1, 4, S_MY);
    add(1, 0, 0, 0, 1, 1, S_SGB);
    add(1, 0, 0, 1, 1, 1, S_SGB);
    add(1, 0, 0, 0, 1, 6, S_SGB);
    add(1, 0, 0, 0, 1, 4, S_SY);
    add(1, 0, 0, 0, 1, 1, S_WALK);
    add(1, 0, 0, 1, 1, 1, S_WALK);
    add(1, 0, 0, 0, 1, 3, S_WALK);
    add(1, 0, 0, 0, 1, 8, S_MGB);
    add(1, 0, 0, 0, 1, 4, S_MY);
    add(1, 0, 0, 0, 1, 8, S_SGB);
    add(1, 0, 0, 0, 1, 4, S_SY);
    // request on the WALK entry edge is consumed
    add(1, 0, 0, 1, 1, 1, S_WALK);
    add(1, 0, 0, 0, 1, 4, S_WALK);
    add(1, 0, 0, 0, 1, 8, S_MGB);
    add(1, 0, 0, 0, 1, 4, S_MY);
    add(1, 0, 0, 0, 1, 8, S_SGB);
    add(1, 0, 0, 0, 1, 4, S_SY);
    add(1, 0, 0, 0, 1, 1, S_MGB);

    foreach (tbl[i]) begin
      tag = $sformatf("vec%0d", i);
      apply(tbl[i]);
    end

    // reprogram in SY with a walk pending
    run("rp_mg",   1, 0, 0, 0, 1, 7, S_MGB);
    run("rp_my_w", 1, 0, 0, 1, 1, 1, S_MY);
    run("rp_my",   1, 0, 0, 0, 1, 3, S_MY);
    run("rp_sg",   1, 0, 0, 0, 1, 8, S_SGB);
    run("rp_sy",   1, 0, 0, 0, 1, 2, S_SY);
    run("rp_hold", 1, 1, 0, 0, 1, 2, S_MGB);
    run("rp_load", 1, 0, 0, 0, 1, 7, S_MGB);
    run("rp_my2",  1, 0, 0, 0, 1, 4, S_MY);
    run("rp_sg2",  1, 0, 0, 0, 1, 8, S_SGB);
    run("rp_sy2",  1, 0, 0, 0, 1, 4, S_SY);
    run("rp_walk", 1, 0, 0, 0, 1, 1, S_WALK);

    // ticks in the load phase and on the load edge are ignored
    run("lt_rst",  0, 0, 0, 0, 0, 1, S_MGB);
    run("lt_load", 1, 0, 0, 0, 1, 2, S_MGB);
    for (int k = 0; k < 5; k++) begin
      run("lt_gap",  1, 0, 0, 0, 0, 1, S_MGB);
      run("lt_tick", 1, 0, 0, 0, 1, 1, S_MGB);
    end
    run("lt_gap",  1, 0, 0, 0, 0, 1, S_MGB);
    run("lt_exp",  1, 0, 0, 0, 1, 1, S_MY);

    // asynchronous reset in the middle of MY
    run("ar_my",   1, 0, 0, 0, 1, 1, S_MY);
    #2;
    rst_n = 1'b0;
    #1;
    tag = "ar_async";
    check(S_MGB);
    run("ar_hold", 0, 0, 0, 0, 1, 1, S_MGB);
    run("ar_mg",   1, 0, 0, 0, 1, 7, S_MGB);
    run("ar_my2",  1, 0, 0, 0, 1, 1, S_MY);

    // time_value of 0 loads as a one-tick interval
    tv_zero = 1'b1;
    run("tz_rst",  0, 0, 0, 0, 0, 1, S_MGB);
    run("tz_mg",   1, 0, 0, 0, 1, 2, S_MGB);
    tv_zero = 1'b0;
    run("tz_my",   1, 0, 0, 0, 1, 4, S_MY);
    run("tz_sg",   1, 0, 0, 0, 1, 1, S_SGB);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/traffic_light_fsm.md
Name: traffic_light_fsm

Overview:
- Main sequencing controller for the intersection: owns the state machine, requests interval lengths from the time-parameter block, and counts them down with a 1 Hz enable.
- Drives main-street lamps, side-street lamps and the pedestrian walk lamp.
- Handles the side-street traffic sensor, the latched walk request, and restart on reprogram.
- Sits between the time-parameter block (interval select out, time value in) and the lamp drivers.

Parameters:
- BASE_SEL, 2'b00, interval select code for the base interval
- EXT_SEL, 2'b01, interval select code for the extended interval
- YEL_SEL, 2'b10, interval select code for the yellow interval
- LOAD_LATENCY, 2, clocks from state entry to the timer load edge; covers the time-parameter block's registered output

Ports:
- clk  in  1  system clock
- global_reset_n  in  1  asynchronous, active-low reset
- sec_tick  in  1  one-clk-wide pulse, once per second
- sensor  in  1  side-street traffic present (level)
- walk_request  in  1  pedestrian button; pulse or level
- reprogram  in  1  time-parameter reprogram in progress
- time_value  in  4  interval length in seconds, from the time-parameter block
- interval_sel  out  2  requested interval code, to the time-parameter block
- main_lights  out  3  {red,yellow,green}, one-hot
- side_lights  out  3  {red,yellow,green}, one-hot
- walk_lamp  out  1  pedestrian walk indicator
- state_dbg  out  3  current state encoding

Behaviour:
States and outputs (main / side / walk / interval_sel):
- MG_BASE: G / R / 0 / BASE_SEL
- MG_EXT: G / R / 0 / EXT_SEL
- MY: Y / R / 0 / YEL_SEL
- SG_BASE: R / G / 0 / BASE_SEL
- SG_EXT: R / G / 0 / EXT_SEL
- SY: R / Y / 0 / YEL_SEL
- WALK: R / R / 1 / EXT_SEL

Output timing:
- All outputs decode combinationally from the state register, so they change on the same edge as the state.
- Encoding is 0..6 in the listed order; this value appears on state_dbg.

Transitions (taken only on timer expiry):
- MG_BASE -> MG_EXT if sensor=1, else MY. Sensor is sampled on the expiry cycle.
- MG_EXT -> MY
- MY -> SG_BASE
- SG_BASE -> SG_EXT if sensor=1, else SY
- SG_EXT -> SY
- SY -> WALK if walk_pending=1, else MG_BASE
- WALK -> MG_BASE

Timer load:
- State entry edge E starts a load phase in which a load counter runs and the timer is not armed.
- At edge E+LOAD_LATENCY the timer loads time_value and arms.
- A time_value of 0 loads as 1.
- sec_tick during the load phase is ignored.

Countdown:
- While armed, each sec_tick decrements the 4-bit timer.
- Expiry is sec_tick with timer==1; that edge is also the next state's entry edge.
- An interval of N therefore lasts exactly N sec_ticks after the load.
- The timer never wraps below 0.

Walk request:
- walk_pending sets on any clk with walk_request=1.
- It clears on the edge entering WALK.
- A request asserted in the same cycle as the WALK entry edge does not re-set it; it is consumed.
- Requests arriving during WALK set it again, so another walk is served next cycle round.

Reprogram (priority over everything except reset):
- While reprogram=1: state is forced to MG_BASE, the timer disarms, and the load counter is held at 0.
- walk_pending is preserved.
- On the first clk with reprogram=0, a fresh load phase starts, exactly as a state entry.

Reset:
- Asynchronous on global_reset_n low.
- Reset values: state=MG_BASE, timer=0, disarmed, load counter=0, walk_pending=0.
- Output values in reset: main_lights=001, side_lights=100, walk_lamp=0, interval_sel=00, state_dbg=0.
- Release behaves like a MG_BASE entry: load at the LOAD_LATENCY-th edge after release.
- Reset asserted mid-interval aborts immediately.

Simultaneous events:
- sec_tick on the load edge is ignored; the loaded value is not decremented.
- Expiry together with reprogram: reprogram wins.

Test Plan:
- Reset, sensor=0, no walk, intervals 6/3/2: MG_BASE green for 6 ticks, then MY 2, SG_BASE 6, SY 2, back to MG_BASE. interval_sel sequence is 00, 10, 00, 10.
- sensor=1 throughout: MG_BASE 6 -> MG_EXT 3 (interval_sel=01) -> MY 2 -> SG_BASE 6 -> SG_EXT 3 -> SY 2 -> MG_BASE.
- walk_request pulse during SG_BASE: after SY, enter WALK for 3 ticks with walk_lamp=1 and both lamp sets=100, then MG_BASE. A second pulse during WALK forces WALK again on the next cycle round.
- sec_tick held high every clk, plus a sec_tick on the load edge: first decrement occurs the edge after the load. An interval of 6 lasts 6 ticks after the load edge, i.e. 8 clks including the 2-clk load phase.
- reprogram pulse during SY with walk_pending=1: immediate MG_BASE and main_lights=001. After deassert, load occurs 2 clks later, and the walk is still served after the next SY.
- global_reset_n low mid-MY: outputs immediately 001/100/0. After release, MG_BASE lasts the full base interval. time_value=0 on load yields a 1-tick interval.
